// File: rtl/tempo_sequencer.sv
// Game-phase controller: sequences countdown/play/pause/level-up/over and drives the beat divider.
// Latency: all outputs registered; a beat edge is counted one cycle after it appears on beat.
// Backpressure: none; pulse inputs are consumed in the cycle they arrive, or dropped where the state ignores them.
module tempo_sequencer #(
    parameter logic [26:0] MAX_L0          = 27'd24_999_999,
    parameter logic [26:0] STEP            = 27'd2_500_000,
    parameter logic [26:0] MIN_MAX         = 27'd4_999_999,
    parameter int          BEATS_PER_LEVEL = 16,
    parameter int          LEVELS          = 8,
    parameter int          COUNTDOWN_BEATS = 3,
    parameter int          MISS_LIMIT      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause_req,
    input  logic        beat,
    input  logic        hit,
    input  logic        miss,
    output logic [26:0] div_max,
    output logic        div_pause,
    output logic        div_reset,
    output logic [2:0]  state,
    output logic [2:0]  level,
    output logic [7:0]  beat_cnt,
    output logic [7:0]  score,
    output logic [3:0]  miss_cnt,
    output logic        game_over,
    output logic        win
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_LEVEL_UP  = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    // Last-count comparisons are done against limit-1 so the counters never need a carry bit.
    localparam logic [7:0] BPL_LAST   = 8'(BEATS_PER_LEVEL - 1);
    localparam logic [7:0] CD_LAST    = 8'(COUNTDOWN_BEATS - 1);
    localparam logic [3:0] MISS_LAST  = 4'(MISS_LIMIT - 1);
    localparam logic [2:0] LEVEL_LAST = 3'(LEVELS - 1);
    // Floor threshold in 28 bits so MIN_MAX+STEP cannot wrap.
    localparam logic [27:0] FLOOR_THRESH = {1'b0, MIN_MAX} + {1'b0, STEP};

    state_t      st;
    logic        beat_q;
    logic        tick;
    logic [26:0] max_dec;
    logic [7:0]  score_inc;

    assign state     = st;
    assign tick      = beat ^ beat_q;
    assign score_inc = (score == 8'hFF) ? score : score + 8'd1;
    // Next tempo: step down, clamped at the floor without ever subtracting past it.
    assign max_dec   = ({1'b0, div_max} < FLOOR_THRESH) ? MIN_MAX : div_max - STEP;

    // Beat edge detector: previous beat level.
    always_ff @(posedge clk) begin
        if (reset) beat_q <= 1'b0;
        else       beat_q <= beat;
    end

    // Game-phase state machine with all divider controls and counters registered.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            div_max   <= MAX_L0;
            level     <= 3'd0;
            beat_cnt  <= 8'd0;
            score     <= 8'd0;
            miss_cnt  <= 4'd0;
            game_over <= 1'b0;
            win       <= 1'b0;
            if (reset) begin
                st        <= S_IDLE;
                div_pause <= 1'b1;
                div_reset <= 1'b1;
            end else begin
                st        <= S_COUNTDOWN;
                div_pause <= 1'b0;
                div_reset <= 1'b0;
            end
        end else begin
            case (st)
                S_IDLE: begin
                    // Counters were cleared on entry; nothing moves until start.
                end
                S_COUNTDOWN: begin
                    if (tick) begin
                        if (beat_cnt == CD_LAST) begin
                            beat_cnt <= 8'd0;
                            st       <= S_PLAY;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick) beat_cnt <= beat_cnt + 8'd1;
                    if (hit)  score    <= score_inc;
                    if (miss) miss_cnt <= miss_cnt + 4'd1;
                    if (miss && miss_cnt == MISS_LAST) begin
                        st        <= S_OVER;
                        win       <= 1'b0;
                        game_over <= 1'b1;
                        div_pause <= 1'b1;
                    end else if (tick && beat_cnt == BPL_LAST) begin
                        st        <= S_LEVEL_UP;
                        div_reset <= 1'b1;
                    end else if (pause_req) begin
                        st        <= S_PAUSED;
                        div_pause <= 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (pause_req) begin
                        st        <= S_PLAY;
                        div_pause <= 1'b0;
                    end
                end
                S_LEVEL_UP: begin
                    div_reset <= 1'b0;
                    if (level == LEVEL_LAST) begin
                        st        <= S_OVER;
                        win       <= 1'b1;
                        game_over <= 1'b1;
                        div_pause <= 1'b1;
                    end else begin
                        level    <= level + 3'd1;
                        div_max  <= max_dec;
                        beat_cnt <= 8'd0;
                        st       <= S_PLAY;
                    end
                end
                S_OVER: begin
                    // Final tallies hold until start.
                end
                default: begin
                    st        <= S_IDLE;
                    div_max   <= MAX_L0;
                    div_pause <= 1'b1;
                    div_reset <= 1'b1;
                    level     <= 3'd0;
                    beat_cnt  <= 8'd0;
                    score     <= 8'd0;
                    miss_cnt  <= 4'd0;
                    game_over <= 1'b0;
                    win       <= 1'b0;
                end
            endcase
        end
    end

endmodule
